// File: rtl/operand_reader.sv
// rtl/operand_reader.sv - fetches 64-bit SRAM words over an address range and streams them as two operands each
module operand_reader #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int ADDR_W        = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr_i,
    input  logic [ADDR_W-1:0]        read_end_addr_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic                     mem_rd_en_o,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic [DATA_W-1:0]        op_o,
    output logic                     op_valid_o,
    input  logic                     op_ready_i,
    output logic                     op_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        end_q, end_d;
    logic [MEM_WORD_SIZE-1:0] word_q, word_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = read_start_addr_i;
                    end_d   = read_end_addr_i;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                word_d  = mem_rdata_i;
                state_d = S_LOW;
            end
            S_LOW: begin
                if (op_ready_i) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (op_ready_i) begin
                    if (addr_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Address wraps naturally at 2^ADDR_W, so end < start reads through zero.
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode from registered state only; nothing combinational from op_ready_i or mem_rdata_i.
    assign mem_addr_o  = addr_q;
    assign mem_rd_en_o = (state_q == S_READ);
    assign op_valid_o  = (state_q == S_LOW) || (state_q == S_HIGH);
    assign op_o        = (state_q == S_LOW)  ? word_q[DATA_W-1:0] :
                         (state_q == S_HIGH) ? word_q[MEM_WORD_SIZE-1:DATA_W] : '0;
    assign op_last_o   = (state_q == S_HIGH) && (addr_q == end_q);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_operand_reader.sv
// tb/tb_operand_reader.sv - randomized self-checking bench for operand_reader against a queue-based reference
module tb_operand_reader;
    localparam int DW = 32;
    localparam int MW = 64;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] read_start_addr_i;
    logic [AW-1:0] read_end_addr_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rd_en_o;
    logic [MW-1:0] mem_rdata_i;
    logic [DW-1:0] op_o;
    logic          op_valid_o;
    logic          op_ready_i;
    logic          op_last_o;
    logic          busy_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    logic [MW-1:0] mem [0:(1<<AW)-1];

    operand_reader #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .read_start_addr_i (read_start_addr_i),
        .read_end_addr_i   (read_end_addr_i),
        .mem_addr_o        (mem_addr_o),
        .mem_rd_en_o       (mem_rd_en_o),
        .mem_rdata_i       (mem_rdata_i),
        .op_o              (op_o),
        .op_valid_o        (op_valid_o),
        .op_ready_i        (op_ready_i),
        .op_last_o         (op_last_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    // SRAM: data one cycle after rd_en, garbage on every other cycle.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rdata_i <= mem[mem_addr_o];
        else             mem_rdata_i <= {$urandom(), $urandom()};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_rden"},  mem_rd_en_o, 0);
        check({tag, "_op"},    op_o, 0);
        check({tag, "_valid"}, op_valid_o, 0);
        check({tag, "_last"},  op_last_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
    endtask

    // pct >= 0: ready with that percentage; pct < 0: ready only after 3 stalled cycles.
    // rst_at >= 0: assert reset when that many operands have been accepted.
    task automatic run_seq(input logic [AW-1:0] s, input logic [AW-1:0] e, input int pct,
                           input bit timing, input int rst_at);
        logic [DW-1:0] eop[$];
        bit            elast[$];
        logic [AW-1:0] eaddr[$];
        logic [AW-1:0] span, a;
        logic [DW-1:0] prev_op;
        bit            prev_valid, prev_ready, done_seen, rdy;
        int            n, popped, hold, budget;

        span = e - s;
        n    = int'(span) + 1;
        for (int k = 0; k < n; k++) begin
            a = s + AW'(k);
            eaddr.push_back(a);
            eop.push_back(mem[a][DW-1:0]);
            elast.push_back(1'b0);
            eop.push_back(mem[a][MW-1:DW]);
            elast.push_back(k == n - 1);
        end

        read_start_addr_i = s;
        read_end_addr_i   = e;
        start_i           = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        prev_valid = 0;
        prev_ready = 0;
        prev_op    = '0;
        done_seen  = 0;
        popped     = 0;
        hold       = 0;
        budget     = 40 * n + 40;

        for (int cyc = 1; cyc <= budget && !done_seen; cyc++) begin
            if (mem_rd_en_o) begin
                if (eaddr.size() == 0) check("extra_read", 1, 0);
                else                   check("rd_addr", mem_addr_o, eaddr.pop_front());
            end
            if (timing) begin
                check("rd_en_timing", mem_rd_en_o, (cyc % 4 == 1) && (cyc < 4 * n));
                check("valid_timing", op_valid_o, (cyc % 4 == 3 || cyc % 4 == 0) && (cyc <= 4 * n));
                check("done_timing", done_o, cyc == 4 * n + 1);
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", op_valid_o, 1);
                check("hold_op", op_o, prev_op);
            end
            if (op_valid_o) begin
                if (eop.size() == 0) check("extra_op", 1, 0);
                else begin
                    check("op", op_o, eop[0]);
                    check("last", op_last_o, elast[0]);
                end
            end else begin
                check("op_zero", op_o, 0);
                check("last_zero", op_last_o, 0);
            end
            check("busy", busy_o, 1);

            if (done_o) begin
                check("done_drained", eop.size() + eaddr.size(), 0);
                done_seen  = 1;
                start_i    = 1'b0;
                op_ready_i = 1'b0;
            end else begin
                if (rst_at >= 0 && popped == rst_at && op_valid_o) begin
                    rst_i      = 1'b1;
                    op_ready_i = 1'b1;
                    start_i    = 1'b0;
                    @(negedge clk);
                    rst_i      = 1'b0;
                    op_ready_i = 1'b0;
                    check_idle_outputs("after_reset");
                    repeat (4) begin
                        @(negedge clk);
                        check("no_done_after_abort", done_o, 0);
                        check("idle_after_abort", busy_o, 0);
                    end
                    return;
                end
                if (pct < 0) begin
                    rdy  = op_valid_o && (hold == 3);
                    hold = !op_valid_o ? hold : (rdy ? 0 : hold + 1);
                end else begin
                    rdy = ($urandom_range(0, 99) < pct);
                end
                op_ready_i = rdy;
                if (op_valid_o && rdy) begin
                    void'(eop.pop_front());
                    void'(elast.pop_front());
                    popped++;
                end
                prev_valid = op_valid_o;
                prev_ready = rdy;
                prev_op    = op_o;
                // Stray start pulses and address noise while busy must be ignored.
                start_i           = ($urandom_range(0, 4) == 0);
                read_start_addr_i = AW'($urandom());
                read_end_addr_i   = AW'($urandom());
                @(negedge clk);
            end
        end

        check("done_seen", done_seen, 1);
        @(negedge clk);
        check("busy_after_done", busy_o, 0);
        check("done_one_pulse", done_o, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom(), $urandom()};
        rst_i             = 1'b1;
        start_i           = 1'b0;
        read_start_addr_i = '0;
        read_end_addr_i   = '0;
        op_ready_i        = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_i = 1'b0;

        mem[5] = 64'hDEADBEEF_12345678;
        run_seq(10'd5, 10'd5, 100, 1'b1, -1);

        for (int i = 0; i < 3; i++) mem[i] = {32'(i + 'h100), 32'(i)};
        run_seq(10'd0, 10'd2, 100, 1'b1, -1);

        run_seq(10'd10, 10'd13, -1, 1'b0, -1);
        run_seq(10'd40, 10'd45, 40, 1'b0, -1);
        run_seq(10'h3FF, 10'h000, 60, 1'b0, -1);

        run_seq(10'd20, 10'd22, 100, 1'b0, 3);
        run_seq(10'd20, 10'd22, 100, 1'b1, -1);

        run_seq(10'd7, 10'd7, 100, 1'b1, -1);

        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] rs;
            rs = AW'($urandom());
            run_seq(rs, rs + AW'($urandom_range(0, 5)), $urandom_range(30, 100), 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
